// File: rtl/sram_req_adapter.sv
// Valid/ready front-end for a single-port masked SRAM macro: zero-fill sweep after
// reset, then request-to-macro mapping with a 2-entry read response FIFO.
module sram_req_adapter #(
   parameter int unsigned ADDR_WIDTH    = 9,
   parameter int unsigned DATA_WIDTH    = 256,
   parameter int unsigned MASK_WIDTH    = 32,
   parameter bit          INIT_ON_RESET = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [MASK_WIDTH-1:0] req_be_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  init_done_o,
   output logic                  sram_en_o,
   output logic                  sram_wmode_o,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic [MASK_WIDTH-1:0] sram_wmask_o,
   output logic [DATA_WIDTH-1:0] sram_wdata_o,
   input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                state_reg;
   logic [ADDR_WIDTH-1:0] init_cnt_reg;
   logic                  init_done_reg;
   logic                  infl_reg;
   logic [1:0]            count_reg;
   logic                  wr_ptr_reg;
   logic                  rd_ptr_reg;
   logic [DATA_WIDTH-1:0] fifo_mem [2];

   logic       push;
   logic       pop;
   logic [2:0] credit_used;
   logic       req_fire;
   logic       read_issue;

   // A read may issue only if its data will find a free slot when it lands next cycle.
   assign push        = infl_reg;
   assign pop         = (count_reg != 2'd0) & rsp_ready_i;
   assign credit_used = {1'b0, count_reg} + {2'b00, infl_reg} - {2'b00, pop};
   assign req_ready_o = (state_reg == ST_RUN) & (req_we_i | (credit_used < 3'd2));
   assign req_fire    = req_valid_i & req_ready_o;
   assign read_issue  = req_fire & ~req_we_i;

   assign rsp_valid_o = (count_reg != 2'd0);
   assign rsp_rdata_o = fifo_mem[rd_ptr_reg];
   assign init_done_o = init_done_reg;

   always_comb begin
      sram_en_o    = req_fire;
      sram_wmode_o = req_we_i;
      sram_addr_o  = req_addr_i;
      sram_wmask_o = req_be_i;
      sram_wdata_o = req_wdata_i;
      if (state_reg == ST_INIT) begin
         sram_en_o    = 1'b1;
         sram_wmode_o = 1'b1;
         sram_addr_o  = init_cnt_reg;
         sram_wmask_o = '1;
         sram_wdata_o = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= INIT_ON_RESET ? ST_INIT : ST_RUN;
         init_cnt_reg  <= '0;
         init_done_reg <= !INIT_ON_RESET;
         infl_reg      <= 1'b0;
         count_reg     <= 2'd0;
         wr_ptr_reg    <= 1'b0;
         rd_ptr_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_INIT: begin
               init_cnt_reg <= init_cnt_reg + ADDR_WIDTH'(1);
               if (init_cnt_reg == {ADDR_WIDTH{1'b1}}) begin
                  state_reg     <= ST_RUN;
                  init_done_reg <= 1'b1;
               end
            end
            default: state_reg <= ST_RUN;
         endcase
         infl_reg  <= read_issue;
         count_reg <= count_reg + 2'(push) - 2'(pop);
         if (push) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      end
   end

   // Response storage carries no reset; occupancy alone defines validity.
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr_reg] <= sram_rdata_i;
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push && count_reg == 2'd2));

endmodule
